fir_tap_mac: RTL
================

Name: fir_tap_mac

Overview:
- Downstream consumer of the addressable sample delay line in the EQ filter datapath.
- On each new audio sample it does three things:
  - pulses the delay line's shift enable;
  - walks the tap address 0..NUM-1, so the delay line and the coefficient ROM both answer with 1-cycle registered latency;
  - multiplies each tap by its coefficient, accumulates, then rounds and saturates to one output sample.
- Output feeds the next biquad/EQ band or the output serializer.

Parameters:
- IN_WIDTH, 24, sample width (signed, two's complement); applies to tap data and output.
- COEF_WIDTH, 18, coefficient width (signed, Q2.16 at default).
- FRAC_BITS, 16, fractional bits of the coefficient; the product is shifted right by this amount.
- NUM, 3, number of taps; equals the delay-line depth.
- ACC_WIDTH, IN_WIDTH+COEF_WIDTH+$clog2(NUM)+1, accumulator width; guaranteed no internal overflow.

Ports:
- ic_clk  in  1  clock
- ic_rst  in  1  synchronous active-high reset
- ic_sample_valid  in  1  one-cycle strobe: new input sample is present at the delay-line input
- oc_sr_en  out  1  shift enable to the delay line (its ic_en)
- oc_addr  out  NUM  tap address, shared by the delay line ic_addr and the coefficient ROM address
- id_tap_data  in  IN_WIDTH  signed tap from the delay line od_data_out (1-cycle registered)
- id_coef  in  COEF_WIDTH  signed coefficient from the ROM (1-cycle registered)
- od_sample_out  out  IN_WIDTH  signed filtered sample; holds its value between updates
- oc_sample_valid  out  1  one-cycle pulse: od_sample_out was updated
- oc_busy  out  1  high while a computation is in flight
- oc_overrun  out  1  one-cycle pulse: ic_sample_valid was dropped

Behaviour:
- Clock and reset: one clock, ic_clk; ic_rst is synchronous, active-high, and overrides everything, including mid-computation.
- Reset state:
  - FSM goes to IDLE; accumulator and product register are cleared.
  - All outputs are 0, including od_sample_out.
- FSM states: IDLE, SHIFT, MAC, DRAIN, OUT. All outputs are registered or Moore-decoded from state/counter.
- Cycle timeline, with ic_sample_valid sampled high in IDLE at cycle T:
  - T+1, SHIFT: oc_sr_en=1 for exactly one cycle; accumulator cleared.
  - T+2..T+1+NUM, MAC: oc_addr = i for i = 0..NUM-1, one per cycle.
  - T+3+i: id_tap_data and id_coef for tap i are valid; the full-precision signed product is registered at the end of this cycle.
  - T+4+i: acc += sign-extended product.
  - DRAIN: 2 cycles (T+2+NUM, T+3+NUM) to flush the pipeline; oc_addr holds NUM-1.
  - T+4+NUM, OUT: the final acc is rounded and saturated into od_sample_out.
  - T+5+NUM: oc_sample_valid=1 and the FSM is back in IDLE.
- Latency: ic_sample_valid to oc_sample_valid is NUM+5 cycles (8 at default).
- Minimum accepted sample spacing is NUM+5 cycles: a strobe in the same cycle oc_sample_valid is high is accepted.
- oc_busy is high in SHIFT, MAC, DRAIN and OUT (T+1..T+4+NUM).
- A strobe while oc_busy=1 is dropped: no effect on the computation, and oc_overrun pulses high in the following cycle.
- In IDLE: oc_addr=0 and oc_sr_en=0. Addresses >= NUM are never issued.
- Rounding: add 2^(FRAC_BITS-1) to acc, then arithmetic shift right by FRAC_BITS (round half toward +inf).
- Saturation: clamp to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1].
- od_sample_out changes only in OUT or on reset.

Decomposition:
- Shared package eq_pkg contains:
  - the FSM state enum fir_mac_state_t;
  - constants SAMPLE_MAX and SAMPLE_MIN as functions of the width;
  - function acc_width() for the ACC_WIDTH derivation.
- One sub-module, eq_round_sat: combinational round-and-saturate from ACC_WIDTH down to IN_WIDTH, parameterised by FRAC_BITS. It is reused by the future IIR stage.
- Bench instantiates this block together with the delay line and a registered coefficient ROM model.

Test Plan:
- Impulse:
  - Setup: coefs {65536, 32768, 16384}; samples 1000, 0, 0, each strobed 8 cycles apart.
  - Required: outputs 1000, 500, 250. Each oc_sample_valid arrives exactly 8 cycles after its strobe, and oc_sr_en pulses once at strobe+1.
- Saturation:
  - Setup: all coefs 65536.
  - Stimulus and required response:
    - three samples of 8388607 -> third output 8388607;
    - three samples of -8388608 -> third output -8388608.
- Rounding: coef0=32768, others 0; sample 3 -> output 2; sample -3 -> output -1.
- Overrun:
  - Stimulus: a second strobe at T+3 (busy).
  - Required:
    - oc_overrun pulses at T+4;
    - oc_sr_en still pulses only once;
    - the result matches the single-sample result.
  - Stimulus: a strobe at T+8, the same cycle as oc_sample_valid.
  - Required: accepted, with no overrun.
- Reset mid-op:
  - Stimulus: assert ic_rst at T+4 for 1 cycle.
  - Required:
    - next cycle: all outputs 0 and FSM in IDLE;
    - no oc_sample_valid for the aborted sample;
    - a fresh strobe then produces a correct result.
- Address sweep: check that oc_addr sequence 0, 1, 2 appears on cycles T+2..T+4, then holds at 2 through DRAIN, then returns to 0 in IDLE.

Source files
------------

// File: rtl/eq_pkg.sv
// Shared types and helpers for the EQ filter datapath: MAC FSM states,
// sample clamp limits and accumulator sizing.
package eq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        DRAIN,
        OUT
    } fir_mac_state_t;

    function automatic longint sample_max(input int width);
        return (longint'(1) <<< (width - 1)) - 1;
    endfunction

    function automatic longint sample_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    // Product width plus enough growth for NUM additions, plus a guard bit.
    function automatic int acc_width(input int in_width, input int coef_width, input int num);
        return in_width + coef_width + $clog2(num) + 1;
    endfunction

    localparam longint SAMPLE_MAX = sample_max(24);
    localparam longint SAMPLE_MIN = sample_min(24);

endpackage

// File: rtl/eq_round_sat.sv
// Combinational round-half-up and saturate from an accumulator down to sample width.
// Shared by the FIR tap MAC and the IIR stage.
module eq_round_sat
    import eq_pkg::*;
#(
    parameter int ACC_WIDTH = 45,
    parameter int OUT_WIDTH = 24,
    parameter int FRAC_BITS = 16
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] sample
);

    // One extra bit so adding the half-LSB can never wrap.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] MAXV = RW'(sample_max(OUT_WIDTH));
    localparam logic signed [RW-1:0] MINV = RW'(sample_min(OUT_WIDTH));

    logic signed [RW-1:0] rounded;
    logic signed [RW-1:0] shifted;

    always_comb begin
        rounded = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
        shifted = rounded >>> FRAC_BITS;
        if (shifted > MAXV) begin
            sample = MAXV[OUT_WIDTH-1:0];
        end else if (shifted < MINV) begin
            sample = MINV[OUT_WIDTH-1:0];
        end else begin
            sample = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fir_tap_mac.sv
// FIR tap multiply-accumulate: shifts the delay line once per sample, walks the taps,
// accumulates tap*coef and emits one rounded, saturated output sample.
module fir_tap_mac
    import eq_pkg::*;
#(
    parameter int IN_WIDTH   = 24,
    parameter int COEF_WIDTH = 18,
    parameter int FRAC_BITS  = 16,
    parameter int NUM        = 3,
    parameter int ACC_WIDTH  = acc_width(IN_WIDTH, COEF_WIDTH, NUM)
) (
    input  logic                  ic_clk,
    input  logic                  ic_rst,
    input  logic                  ic_sample_valid,
    output logic                  oc_sr_en,
    output logic [NUM-1:0]        oc_addr,
    input  logic [IN_WIDTH-1:0]   id_tap_data,
    input  logic [COEF_WIDTH-1:0] id_coef,
    output logic [IN_WIDTH-1:0]   od_sample_out,
    output logic                  oc_sample_valid,
    output logic                  oc_busy,
    output logic                  oc_overrun
);

    localparam int PW = IN_WIDTH + COEF_WIDTH;
    localparam logic [NUM-1:0] LAST_ADDR = NUM'(NUM - 1);

    fir_mac_state_t          state;
    logic                    drain_cnt;
    logic                    tap_stage;
    logic                    prod_valid;
    logic signed [PW-1:0]    prod;
    logic [ACC_WIDTH-1:0]    acc;
    logic [IN_WIDTH-1:0]     rounded_sample;

    eq_round_sat #(
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(IN_WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) u_round_sat (
        .acc   (acc),
        .sample(rounded_sample)
    );

    assign oc_sr_en = (state == SHIFT);
    assign oc_busy  = (state != IDLE);

    // tap_stage marks cycles where the registered tap/coef pair is valid;
    // prod_valid trails it by one, when the product register is ready to add.
    always_ff @(posedge ic_clk) begin
        if (ic_rst) begin
            state           <= IDLE;
            oc_addr         <= '0;
            drain_cnt       <= 1'b0;
            tap_stage       <= 1'b0;
            prod_valid      <= 1'b0;
            prod            <= '0;
            acc             <= '0;
            od_sample_out   <= '0;
            oc_sample_valid <= 1'b0;
            oc_overrun      <= 1'b0;
        end else begin
            oc_sample_valid <= 1'b0;
            oc_overrun      <= ic_sample_valid && (state != IDLE);
            tap_stage       <= (state == MAC);
            prod_valid      <= tap_stage;
            if (tap_stage) begin
                prod <= PW'($signed(id_tap_data)) * PW'($signed(id_coef));
            end
            if (prod_valid) begin
                acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
            case (state)
                IDLE: begin
                    oc_addr <= '0;
                    if (ic_sample_valid) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    acc     <= '0;
                    oc_addr <= '0;
                    state   <= MAC;
                end
                MAC: begin
                    if (oc_addr == LAST_ADDR) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else begin
                        oc_addr <= oc_addr + NUM'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state <= OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                OUT: begin
                    od_sample_out   <= rounded_sample;
                    oc_sample_valid <= 1'b1;
                    oc_addr         <= '0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
